// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary-to-BCD converter with saturation to all nines
module bin2bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 4
) (
   input  logic                  iCLK,
   input  logic                  iRST_n,
   input  logic [BIN_W-1:0]      iBIN,
   input  logic                  iSTART,
   output logic [4*DIGITS-1:0]   oDIG,
   output logic                  oBUSY,
   output logic                  oDONE,
   output logic                  oOVF
);
   localparam int W  = (BIN_W > 4*DIGITS) ? BIN_W : 4*DIGITS;
   localparam int CW = $clog2(BIN_W + 1);
   localparam logic [W-1:0]  MAXV = W'(10**DIGITS - 1);
   localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   state_t              state;
   logic [BIN_W-1:0]    shReg;
   logic [4*DIGITS-1:0] bcd, bcdAdj;
   logic [CW-1:0]       cnt;
   logic                ovfPend;
   logic                tooBig;
   assign tooBig = W'(iBIN) > MAXV;
   // add 3 to every digit that would reach 10 or more after the next shift
   always_comb begin
      bcdAdj = bcd;
      for (int d = 0; d < DIGITS; d++)
         bcdAdj[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
   end
   // control FSM, datapath and registered outputs; results publish only after a full conversion
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state   <= IDLE;
         shReg   <= '0;
         bcd     <= '0;
         cnt     <= '0;
         ovfPend <= 1'b0;
         oDIG    <= '0;
         oBUSY   <= 1'b0;
         oDONE   <= 1'b0;
         oOVF    <= 1'b0;
      end else begin
         oDONE <= 1'b0;
         case (state)
            IDLE: if (iSTART) begin
               shReg   <= tooBig ? MAXV[BIN_W-1:0] : iBIN;
               ovfPend <= tooBig;
               bcd     <= '0;
               cnt     <= '0;
               oBUSY   <= 1'b1;
               state   <= CONV;
            end
            CONV: begin
               bcd   <= {bcdAdj[4*DIGITS-2:0], shReg[BIN_W-1]};
               shReg <= shReg << 1;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) state <= DONE;
            end
            DONE: begin
               oDIG  <= bcd;
               oOVF  <= ovfPend;
               oDONE <= 1'b1;
               oBUSY <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and randomized checks of bin2bcd_seq at default parameters
module tb_bin2bcd_seq;
   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b1;
   logic [15:0] iBIN = '0;
   logic        iSTART = 1'b0;
   logic [15:0] oDIG;
   logic        oBUSY, oDONE, oOVF;
   int          tests = 0;
   int          fails = 0;
   int          doneCnt;
   int          doneAt[$];

   bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .iBIN(iBIN), .iSTART(iSTART),
      .oDIG(oDIG), .oBUSY(oBUSY), .oDONE(oDONE), .oOVF(oOVF)
   );

   always #10 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] toBcd(input int v);
      int x;
      x = (v > 9999) ? 9999 : v;
      return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
   endfunction

   task automatic run(input logic [15:0] v, input logic [15:0] expDig, input logic expOvf);
      @(negedge iCLK); iBIN = v; iSTART = 1'b1;
      @(negedge iCLK); iSTART = 1'b0;
      chk("busy_after_start", oBUSY, 1);
      repeat (16) @(negedge iCLK);
      chk("no_early_done", oDONE, 0);
      chk("busy_mid", oBUSY, 1);
      @(negedge iCLK);
      chk("done", oDONE, 1);
      chk("dig", oDIG, expDig);
      chk("ovf", oOVF, expOvf);
      chk("busy_idle", oBUSY, 0);
      @(negedge iCLK);
      chk("done_one_cycle", oDONE, 0);
      chk("dig_hold", oDIG, expDig);
   endtask

   initial begin
      #2 iRST_n = 1'b0;
      #1;
      chk("rst_dig", oDIG, 0);
      chk("rst_busy", oBUSY, 0);
      chk("rst_done", oDONE, 0);
      chk("rst_ovf", oOVF, 0);
      repeat (2) @(negedge iCLK);
      iRST_n = 1'b1;
      run(16'd1234, 16'h1234, 1'b0);
      repeat (5) @(negedge iCLK);
      chk("hold_1234", oDIG, 16'h1234);
      run(16'd0, 16'h0000, 1'b0);
      run(16'd9, 16'h0009, 1'b0);
      run(16'd10, 16'h0010, 1'b0);
      run(16'd9999, 16'h9999, 1'b0);
      run(16'd10000, 16'h9999, 1'b1);
      run(16'd65535, 16'h9999, 1'b1);
      run(16'd42, 16'h0042, 1'b0);
      // busy rejection: extra pulses at E+5 and E+17 are ignored
      @(negedge iCLK); iBIN = 16'd5678; iSTART = 1'b1;
      @(negedge iCLK); iSTART = 1'b0;
      doneCnt = 0;
      for (int k = 1; k <= 20; k++) begin
         iSTART = (k == 5 || k == 17);
         if (iSTART) iBIN = 16'd1111;
         @(negedge iCLK);
         if (oDONE) begin
            doneCnt++;
            chk("busy_rej_dig", oDIG, 16'h5678);
         end
      end
      iSTART = 1'b0;
      chk("busy_rej_count", doneCnt, 1);
      chk("busy_rej_final", oDIG, 16'h5678);
      chk("busy_rej_idle", oBUSY, 0);
      // held start: one result every 18 cycles
      @(negedge iCLK); iBIN = 16'd321; iSTART = 1'b1;
      @(negedge iCLK);
      for (int k = 1; k <= 37; k++) begin
         @(negedge iCLK);
         if (oDONE) begin
            doneAt.push_back(k);
            chk("held_dig", oDIG, 16'h0321);
         end
      end
      iSTART = 1'b0;
      chk("held_count", doneAt.size(), 2);
      if (doneAt.size() == 2) begin
         chk("held_first", doneAt[0], 17);
         chk("held_period", doneAt[1] - doneAt[0], 18);
      end
      repeat (20) @(negedge iCLK);
      // asynchronous reset in the middle of a conversion
      @(negedge iCLK); iBIN = 16'd4321; iSTART = 1'b1;
      @(negedge iCLK); iSTART = 1'b0;
      repeat (8) @(negedge iCLK);
      chk("pre_rst_busy", oBUSY, 1);
      #3 iRST_n = 1'b0;
      #1;
      chk("midrst_dig", oDIG, 0);
      chk("midrst_busy", oBUSY, 0);
      chk("midrst_done", oDONE, 0);
      chk("midrst_ovf", oOVF, 0);
      repeat (2) @(negedge iCLK);
      iRST_n = 1'b1;
      doneCnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge iCLK);
         if (oDONE) doneCnt++;
      end
      chk("midrst_no_done", doneCnt, 0);
      chk("midrst_dig_zero", oDIG, 0);
      run(16'd77, 16'h0077, 1'b0);
      // randomized regression against a divide/modulo reference
      for (int i = 0; i < 200; i++) begin
         int v;
         v = (i % 2) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9999));
         run(16'(v), toBcd(v), v > 9999);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
